// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: 4-wide allocate, 4-port writeback, 2-wide retire.
// Optional ROB_BYPASS_EN: broadcast also shows same-cycle writebacks (zero-latency wakeup).

module rob_entry #(
  parameter int TAG_W = 4,
  parameter int VEC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [TAG_W-1:0] alloc_rt_i,
  input  logic             alloc_we_i,
  input  logic             wb_i,
  input  logic [VEC_W-1:0] wb_value_i,
  input  logic             retire_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [TAG_W-1:0] rt_o,
  output logic             we_o,
  output logic [VEC_W-1:0] value_o
);
  logic             busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [TAG_W-1:0] rt_q, rt_d;
  logic [VEC_W-1:0] value_q, value_d;

  // Flush beats retire beats allocate beats writeback; writebacks only land on busy entries.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    rt_d    = rt_q;
    we_d    = we_q;
    value_d = value_q;
    if (flush_i) begin
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rt_d    = '0;
      we_d    = 1'b0;
      value_d = '0;
    end else if (retire_i) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (alloc_i) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      rt_d   = alloc_rt_i;
      we_d   = alloc_we_i;
    end else if (wb_i && busy_q) begin
      done_d  = 1'b1;
      value_d = wb_value_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rt_q    <= '0;
      we_q    <= 1'b0;
      value_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      rt_q    <= rt_d;
      we_q    <= we_d;
      value_q <= value_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign rt_o    = rt_q;
  assign we_o    = we_q;
  assign value_o = value_q;
endmodule

module reorder_buffer (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             alloc_req_i,
  input  logic [3:0][3:0]        alloc_rt_i,
  input  logic [3:0]             alloc_writes_reg_i,
  output logic                   alloc_ready_o,
  output logic [3:0][3:0]        alloc_tag_o,
  input  logic [3:0]             wb_valid_i,
  input  logic [3:0][3:0]        wb_tag_i,
  input  logic [3:0][15:0]       wb_value_i,
  input  logic                   flush_i,
  output logic [15:0]            rob_output_valid_o,
  output logic [15:0][15:0]      rob_output_values_o,
  output logic [1:0]             commit_valid_o,
  output logic [1:0]             commit_we_o,
  output logic [1:0][3:0]        commit_rt_o,
  output logic [1:0][15:0]       commit_value_o,
  output logic [1:0][3:0]        commit_tag_o,
  output logic                   empty_o
);
  localparam int DEPTH     = 16;
  localparam int RETIRE_W  = 2;
  localparam int NUM_LANES = 4;
  localparam int TAG_W     = 4;
  localparam int VEC_W     = 16;

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [4:0]       count_q, count_d;
  logic [2:0]       n_alloc;
  logic [1:0]       n_ret;

  logic [DEPTH-1:0]             busy, done, we, alloc_en, wb_hit, retire_en;
  logic [DEPTH-1:0][TAG_W-1:0]  rt, ent_rt;
  logic [DEPTH-1:0]             ent_we;
  logic [DEPTH-1:0][VEC_W-1:0]  value, wb_val;
  logic [RETIRE_W-1:0]          cv;

  assign alloc_ready_o = (count_q <= 5'd12);
  assign empty_o       = (count_q == 5'd0);

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) alloc_tag_o[i] = tail_q + TAG_W'(i);
  end

  // Slot i lands in entry tail+i; requests are contiguous so a popcount advances tail.
  always_comb begin
    alloc_en = '0;
    ent_rt   = '0;
    ent_we   = '0;
    n_alloc  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (alloc_req_i[i] && alloc_ready_o) begin
        alloc_en[alloc_tag_o[i]] = 1'b1;
        ent_rt[alloc_tag_o[i]]   = alloc_rt_i[i];
        ent_we[alloc_tag_o[i]]   = alloc_writes_reg_i[i];
        n_alloc                  = n_alloc + 3'd1;
      end
    end
  end

  // Scan ports high to low so the lowest index is the last writer.
  always_comb begin
    wb_hit = '0;
    wb_val = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = NUM_LANES - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_tag_i[p] == TAG_W'(e))) begin
          wb_hit[e] = 1'b1;
          wb_val[e] = wb_value_i[p];
        end
      end
    end
  end

  always_comb begin
    cv[0] = !flush_i && busy[head_q] && done[head_q];
    cv[1] = cv[0] && busy[head_q + 4'd1] && done[head_q + 4'd1];
    retire_en = '0;
    n_ret     = '0;
    for (int l = 0; l < RETIRE_W; l++) begin
      retire_en[head_q + TAG_W'(l)] = cv[l];
      commit_valid_o[l] = cv[l];
      commit_we_o[l]    = cv[l] && we[head_q + TAG_W'(l)];
      commit_rt_o[l]    = cv[l] ? rt[head_q + TAG_W'(l)] : '0;
      commit_value_o[l] = cv[l] ? value[head_q + TAG_W'(l)] : '0;
      commit_tag_o[l]   = cv[l] ? head_q + TAG_W'(l) : '0;
      n_ret             = n_ret + {1'b0, cv[l]};
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      rob_entry #(.TAG_W(TAG_W), .VEC_W(VEC_W)) u_ent (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .alloc_i    (alloc_en[g]),
        .alloc_rt_i (ent_rt[g]),
        .alloc_we_i (ent_we[g]),
        .wb_i       (wb_hit[g]),
        .wb_value_i (wb_val[g]),
        .retire_i   (retire_en[g]),
        .busy_o     (busy[g]),
        .done_o     (done[g]),
        .rt_o       (rt[g]),
        .we_o       (we[g]),
        .value_o    (value[g])
      );
    end
  endgenerate

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
`ifdef ROB_BYPASS_EN
      rob_output_valid_o[e]  = (busy[e] && done[e]) || (busy[e] && wb_hit[e] && !flush_i);
      rob_output_values_o[e] = (busy[e] && wb_hit[e] && !flush_i) ? wb_val[e] : value[e];
`else
      rob_output_valid_o[e]  = busy[e] && done[e];
      rob_output_values_o[e] = value[e];
`endif
    end
  end

  always_comb begin
    head_d  = head_q + {2'b00, n_ret};
    tail_d  = tail_q + {1'b0, n_alloc};
    count_d = count_q + {2'b00, n_alloc} - {3'b000, n_ret};
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenarios plus a randomized run against a queue-based ROB model.
module tb_reorder_buffer;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        alloc_req, alloc_we, wb_valid;
  logic [3:0][3:0]   alloc_rt, wb_tag;
  logic [3:0][15:0]  wb_value;
  logic              flush;
  logic              alloc_ready, empty;
  logic [3:0][3:0]   alloc_tag;
  logic [15:0]       rob_valid;
  logic [15:0][15:0] rob_values;
  logic [1:0]        commit_valid, commit_we;
  logic [1:0][3:0]   commit_rt, commit_tag;
  logic [1:0][15:0]  commit_value;
  int total = 0, bad = 0;

`ifdef ROB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_i(alloc_req), .alloc_rt_i(alloc_rt), .alloc_writes_reg_i(alloc_we),
    .alloc_ready_o(alloc_ready), .alloc_tag_o(alloc_tag),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_value_i(wb_value), .flush_i(flush),
    .rob_output_valid_o(rob_valid), .rob_output_values_o(rob_values),
    .commit_valid_o(commit_valid), .commit_we_o(commit_we), .commit_rt_o(commit_rt),
    .commit_value_o(commit_value), .commit_tag_o(commit_tag), .empty_o(empty)
  );

  always #5 clk = ~clk;

  task automatic clr();
    alloc_req = '0; alloc_we = '0; alloc_rt = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", alloc_ready); end
    total++; if (alloc_tag !== 16'h3210) begin bad++; $display("FAIL rst_tag got %h want 3210", alloc_tag); end
    total++; if (rob_valid !== 16'h0 || rob_values !== '0) begin bad++; $display("FAIL rst_rob got %h want 0", rob_valid); end
    total++; if ({commit_valid, commit_we, commit_rt, commit_value, commit_tag} !== '0) begin
      bad++; $display("FAIL rst_commit got %b/%b want 0", commit_valid, commit_we); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got %b want 1", empty); end
  endtask

  task automatic test_alloc();
    alloc_req = 4'b1111; alloc_we = 4'b1111;
    for (int i = 0; i < 4; i++) alloc_rt[i] = 4'(i + 1);
    #1;
    total++; if (alloc_tag !== 16'h3210) begin bad++; $display("FAIL alloc_tag got %h want 3210", alloc_tag); end
    tick(); clr(); #1;
    total++; if (empty !== 1'b0 || alloc_ready !== 1'b1) begin
      bad++; $display("FAIL alloc_state got empty=%b ready=%b want 0/1", empty, alloc_ready); end
    total++; if (alloc_tag !== 16'h7654) begin bad++; $display("FAIL alloc_tail got %h want 7654", alloc_tag); end
    total++; if (rob_valid !== 16'h0) begin bad++; $display("FAIL alloc_vld got %h want 0", rob_valid); end
  endtask

  task automatic test_wb_order();
    wb_valid = 4'b0001; wb_tag[0] = 4'd1; wb_value[0] = 16'h00AA; #1;
    total++; if (rob_valid[1] !== BYP) begin bad++; $display("FAIL wb_bypass1 got %b want %b", rob_valid[1], BYP); end
    tick(); clr(); #1;
    total++; if (rob_valid !== 16'h0002 || rob_values[1] !== 16'h00AA) begin
      bad++; $display("FAIL wb_vld1 got %h/%h want 0002/00aa", rob_valid, rob_values[1]); end
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL wb_nocommit got %b want 00", commit_valid); end
    wb_valid = 4'b0010; wb_tag[1] = 4'd0; wb_value[1] = 16'h0055; #1;
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL wb_commit_wait got %b want 00", commit_valid); end
    tick(); clr(); #1;
    total++; if (commit_valid !== 2'b11 || commit_tag !== {4'd1, 4'd0}) begin
      bad++; $display("FAIL ret2_tag got %b/%h want 11/10", commit_valid, commit_tag); end
    total++; if (commit_value !== {16'h00AA, 16'h0055} || commit_rt !== {4'd2, 4'd1} || commit_we !== 2'b11) begin
      bad++; $display("FAIL ret2_data got %h/%h/%b want 00aa0055/21/11", commit_value, commit_rt, commit_we); end
    tick(); #1;
    total++; if (commit_valid !== 2'b00 || rob_valid !== 16'h0 || empty !== 1'b0) begin
      bad++; $display("FAIL ret2_after got %b/%h/%b want 00/0/0", commit_valid, rob_valid, empty); end
  endtask

  task automatic test_full();
    do_reset();
    alloc_req = 4'b1111;
    tick(); tick(); tick();
    total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL full12_ready got %b want 1", alloc_ready); end
    alloc_req = 4'b0001;
    wb_valid = 4'b0011; wb_tag[0] = 4'd0; wb_tag[1] = 4'd1; wb_value[0] = 16'h1; wb_value[1] = 16'h2;
    tick(); clr(); alloc_req = 4'b1111; #1;
    total++; if (alloc_ready !== 1'b0 || commit_valid !== 2'b11) begin
      bad++; $display("FAIL full13 got ready=%b cv=%b want 0/11", alloc_ready, commit_valid); end
    tick(); clr(); #1;
    total++; if (alloc_ready !== 1'b1 || alloc_tag !== 16'h0FED) begin
      bad++; $display("FAIL full11 got ready=%b tag=%h want 1/0fed", alloc_ready, alloc_tag); end
  endtask

  task automatic test_same_tag();
    do_reset();
    alloc_req = 4'b1111; tick(); tick(); clr();
    wb_valid = 4'b0111;
    wb_tag[0] = 4'd5; wb_value[0] = 16'h1111;
    wb_tag[2] = 4'd5; wb_value[2] = 16'h2222;
    wb_tag[1] = 4'd9; wb_value[1] = 16'h9999;
    tick(); clr(); #1;
    total++; if (rob_valid !== 16'h0020) begin bad++; $display("FAIL same_vld got %h want 0020", rob_valid); end
    total++; if (rob_values[5] !== 16'h1111) begin bad++; $display("FAIL same_val got %h want 1111", rob_values[5]); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 4'b1111; tick();
    alloc_req = 4'b0011; wb_valid = 4'b0001; wb_tag[0] = 4'd0; wb_value[0] = 16'hBEEF; tick(); clr(); #1;
    total++; if (commit_valid !== 2'b01 || commit_value[0] !== 16'hBEEF) begin
      bad++; $display("FAIL flush_pre got %b/%h want 01/beef", commit_valid, commit_value[0]); end
    flush = 1'b1; alloc_req = 4'b1111; wb_valid = 4'b0010; wb_tag[1] = 4'd1; #1;
    total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL flush_cv got %b want 00", commit_valid); end
    tick(); clr(); #1;
    total++; if (empty !== 1'b1 || alloc_tag !== 16'h3210 || rob_valid !== 16'h0) begin
      bad++; $display("FAIL flush_after got %b/%h/%h want 1/3210/0", empty, alloc_tag, rob_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    alloc_req = 4'b0111; tick(); clr();
    wb_valid = 4'b1000; wb_tag[3] = 4'd0; wb_value[3] = 16'h7777; tick(); clr(); #1;
    total++; if (commit_valid !== 2'b01) begin bad++; $display("FAIL arst_pre got %b want 01", commit_valid); end
    #1 rst_n = 1'b0; #1;
    total++; if (empty !== 1'b1 || alloc_tag !== 16'h3210 || commit_valid !== 2'b00 || rob_valid !== 16'h0) begin
      bad++; $display("FAIL arst got %b/%h/%b/%h want 1/3210/00/0", empty, alloc_tag, commit_valid, rob_valid); end
    rst_n = 1'b1; tick();
  endtask

  typedef struct {logic [3:0] tag; logic [3:0] rt; logic we; logic done; logic [15:0] val;} ent_t;

  task automatic test_random();
    ent_t q[$];
    int nxt = 0, retired = 0;
    logic [3:0] last_ret = 4'hF;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int k, nret;
      logic [15:0] evld;
      logic [1:0] ecv;
      logic [3:0][3:0] etag;
      k = $urandom_range(0, 4);
      clr();
      alloc_req = 4'((1 << k) - 1);
      for (int i = 0; i < 4; i++) begin
        alloc_rt[i] = 4'($urandom); alloc_we[i] = 1'($urandom);
        wb_valid[i] = ($urandom_range(0, 9) < 5);
        wb_tag[i]   = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].tag
                                                                  : 4'($urandom);
        wb_value[i] = 16'($urandom);
      end
      flush = ($urandom_range(0, 49) == 0);
      #1;
      for (int i = 0; i < 4; i++) etag[i] = 4'(nxt + i);
      total++; if (alloc_ready !== (q.size() <= 12) || alloc_tag !== etag || empty !== (q.size() == 0)) begin
        bad++; $display("FAIL rnd_alloc c%0d got %b/%h/%b want %b/%h/%b", cyc, alloc_ready, alloc_tag, empty,
                        q.size() <= 12, etag, q.size() == 0); end
      evld = '0;
      foreach (q[j]) begin
        logic hit; logic [15:0] hv;
        hit = 1'b0; hv = '0;
        for (int p = 3; p >= 0; p--)
          if (wb_valid[p] && wb_tag[p] == q[j].tag) begin hit = 1'b1; hv = wb_value[p]; end
        if (BYP && hit && !flush) begin
          evld[q[j].tag] = 1'b1;
          total++; if (rob_values[q[j].tag] !== hv) begin
            bad++; $display("FAIL rnd_byp_val c%0d t%0d got %h want %h", cyc, q[j].tag, rob_values[q[j].tag], hv); end
        end else if (q[j].done) begin
          evld[q[j].tag] = 1'b1;
          total++; if (rob_values[q[j].tag] !== q[j].val) begin
            bad++; $display("FAIL rnd_val c%0d t%0d got %h want %h", cyc, q[j].tag, rob_values[q[j].tag], q[j].val); end
        end
      end
      total++; if (rob_valid !== evld) begin bad++; $display("FAIL rnd_vld c%0d got %h want %h", cyc, rob_valid, evld); end
      nret = 0;
      if (!flush && q.size() > 0 && q[0].done) nret = 1;
      if (nret == 1 && q.size() > 1 && q[1].done) nret = 2;
      ecv = 2'((1 << nret) - 1);
      total++; if (commit_valid !== ecv) begin bad++; $display("FAIL rnd_cv c%0d got %b want %b", cyc, commit_valid, ecv); end
      for (int l = 0; l < 2; l++) begin
        logic [24:0] got, exp;
        got = {commit_tag[l], commit_rt[l], commit_we[l], commit_value[l]};
        exp = (l < nret) ? {q[l].tag, q[l].rt, q[l].we, q[l].val} : '0;
        total++; if (got !== exp) begin bad++; $display("FAIL rnd_lane%0d c%0d got %h want %h", l, cyc, got, exp); end
        if (l < nret) begin
          total++; if (q[l].tag !== 4'(last_ret + 1)) begin
            bad++; $display("FAIL rnd_order c%0d got %0d want %0d", cyc, q[l].tag, 4'(last_ret + 1)); end
          last_ret = q[l].tag;
        end
      end
      if (flush) begin
        q.delete(); nxt = 0; last_ret = 4'hF;
      end else begin
        foreach (q[j])
          for (int p = 3; p >= 0; p--)
            if (wb_valid[p] && wb_tag[p] == q[j].tag) begin q[j].done = 1'b1; q[j].val = wb_value[p]; end
        for (int n = 0; n < nret; n++) void'(q.pop_front());
        retired += nret;
        if (q.size() + nret <= 12)
          for (int i = 0; i < k; i++) begin
            q.push_back('{tag: 4'(nxt), rt: alloc_rt[i], we: alloc_we[i], done: 1'b0, val: 16'h0});
            nxt = (nxt + 1) % 16;
          end
      end
      tick();
    end
    clr();
    total++; if (retired <= 16) begin bad++; $display("FAIL rnd_wrap got %0d retired want >16", retired); end
  endtask

  initial begin
    clr();
    test_reset();
    test_alloc();
    test_wb_order();
    test_full();
    test_same_tag();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry in-order reorder buffer for the 4-wide out-of-order core. Allocates owner tags to up to four decoded instructions per cycle and captures results from the four functional units (fxu_0, fxu_1, lsu, branch). It publishes every entry's completion status and value on the rob_output_valid / rob_output_values broadcast read by the instruction buffer and reservation stations. It retires up to two completed head entries per cycle into the register file.

## Interface
- DEPTH, 16: entry count; tag width is 4 bits; fixed.
- RETIRE_W, 2: maximum retirements per cycle; fixed.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_req[0:3]  in  1  allocation request per decode slot; requests are contiguous from slot 0 (e.g. 1,1,0,0).
- alloc_rt[0:3]  in  4  destination register per slot.
- alloc_writes_reg[0:3]  in  1  slot writes a register.
- alloc_ready  out  1  at least 4 free entries; decode allocates only when high.
- alloc_tag[0:3]  out  4  tag assigned to each slot this cycle.
- wb_valid[0:3]  in  1  writeback from fxu_0, fxu_1, lsu, branch.
- wb_tag[0:3]  in  4  entry being completed.
- wb_value[0:3]  in  16  result.
- flush  in  1  mispredict flush; empties buffer.
- rob_output_valid[0:15]  out  1  entry allocated and completed.
- rob_output_values[0:15]  out  16  entry result.
- commit_valid[0:1]  out  1  retirement lane active.
- commit_we[0:1]  out  1  lane writes register file.
- commit_rt[0:1]  out  4  destination register.
- commit_value[0:1]  out  16  value to write.
- commit_tag[0:1]  out  4  retiring tag; register file clears busy only if its owner equals this tag.
- empty  out  1  count == 0.

## Operation
- State: head[3:0], tail[3:0], count[4:0]; per entry: busy, done, rt, we, value.
- alloc_tag[i] = tail + i (mod 16), combinational from registered tail, regardless of alloc_req.
- Allocation (alloc_req[i] & alloc_ready): entry busy=1, done=0, rt/we latched; tail += number of requests; count += number of requests.
- Writeback: wb_valid[p] to a busy entry sets done=1, value=wb_value[p]. Writeback to a non-busy entry is ignored. Two ports hitting the same tag in one cycle: lowest port index wins.
- Retire: lane 0 active when head entry busy & done; lane 1 active only when lane 0 is active and entry head+1 is busy & done. Retired entries clear busy/done; head += lanes; count -= lanes. No back-pressure from register file.
- flush: all busy/done cleared, head=tail=0, count=0, retirement suppressed that cycle (commit_valid forced 0), allocation and writeback ignored. Flush has highest priority.
- Simultaneous retire and allocate: both apply; alloc_ready uses registered count (count <= 12), not post-retire count.
- Pointer wrap: modulo 16; tag 15 followed by tag 0.
- Reset mid-operation: all state cleared immediately, identical to flush.

## Timing
- Reset values: alloc_ready=1, alloc_tag[i]=i, rob_output_valid all 0, rob_output_values all 0, commit_valid=0, commit_we=0, commit_rt=0, commit_value=0, commit_tag=0, empty=1.
- Allocation to busy: 1 cycle. Writeback to rob_output_valid: see Configuration. Done to commit_valid: combinational from registered done (one cycle after the writeback edge at minimum).
- commit_* outputs are combinational from registered state; the register file samples them on the same posedge that advances head.

## Configuration
- ROB_BYPASS_EN defined: rob_output_valid[t] / rob_output_values[t] also reflect same-cycle wb_valid to busy tag t combinationally (same port priority), giving zero-latency wakeup. Commit is unaffected and still waits for registered done.
- Undefined: broadcast is purely registered; a result is visible the cycle after writeback.

## Test plan
- Reset then alloc_req=1,1,1,1 with rt=1..4 -> alloc_tag=0,1,2,3; next cycle count=4, all rob_output_valid still 0, alloc_ready=1.
- wb tag 1 value 0x00AA, then tag 0 value 0x0055 -> rob_output_valid[1]=1 first (same cycle with ROB_BYPASS_EN), no commit until tag 0 done; then two lanes retire tags 0,1 with values 0x0055, 0x00AA in one cycle.
- Fill to 13 entries -> alloc_ready=0; retiring 2 that cycle still holds alloc_ready=0 until count is registered at 11.
- Run 20 allocate/complete/retire rounds -> tags wrap 15->0 and retire strictly in order, with no lost entries.
- fxu_0 and lsu write tag 5 in the same cycle with 0x1111 / 0x2222 -> value 0x1111. A writeback to a non-busy tag 9 leaves rob_output_valid[9]=0.
- flush with 6 entries pending and head entry done -> commit_valid=0 that cycle; next cycle empty=1 and alloc_tag=0,1,2,3. rst_n low mid-stream gives the same result asynchronously.
